// File: rtl/fetch_stage_pkg.sv
// Shared decode constants and next-PC selection helpers for the fetch stage.
// Opcode/func values match the MIPS subset executed by the core.
package fetch_stage_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] FN_JR      = 6'h08;

  typedef enum logic [1:0] {
    NPC_PC4  = 2'd0,
    NPC_BR   = 2'd1,
    NPC_JIDX = 2'd2,
    NPC_JREG = 2'd3
  } npc_sel_e;

  function automatic npc_sel_e npc_decode(input logic [31:0] instr, input logic cmp_eq);
    npc_sel_e sel;
    sel = NPC_PC4;
    if (instr[31:26] == OP_BEQ && cmp_eq) begin
      sel = NPC_BR;
    end else if (instr[31:26] == OP_J || instr[31:26] == OP_JAL) begin
      sel = NPC_JIDX;
    end else if (instr[31:26] == OP_SPECIAL && instr[5:0] == FN_JR) begin
      sel = NPC_JREG;
    end
    return sel;
  endfunction

  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_npc.sv
// Combinational next-PC selector: resolves beq/j/jal/jr sitting in D,
// otherwise advances the fetch PC by one word. All adds wrap at 32 bits.
module npc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc_f_i,
  input  logic [31:0] pc_d_i,
  input  logic [31:0] instr_d_i,
  input  logic [31:0] rs_fwd_d_i,
  input  logic        cmp_eq_d_i,
  output logic [31:0] npc_o
);

  npc_sel_e sel;

  always_comb begin
    sel   = npc_decode(instr_d_i, cmp_eq_d_i);
    npc_o = pc_f_i + 32'd4;
    case (sel)
      NPC_BR:   npc_o = pc_d_i + 32'd4 + br_offset(instr_d_i[15:0]);
      NPC_JIDX: npc_o = {pc_d_i[31:28], instr_d_i[25:0], 2'b00};
      NPC_JREG: npc_o = rs_fwd_d_i;
      default:  ;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage with the IF/ID pipeline register, stall freeze, ID/EX bubble
// request, saturating stall-cycle counter and sticky misaligned-PC flag.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      instr_F,
  input  logic             cmp_eq_D,
  input  logic [31:0]      rs_fwd_D,
  output logic [31:0]      pc_F,
  output logic [31:0]      instr_D,
  output logic [31:0]      pc_D,
  output logic [31:0]      pc8_D,
  output logic             valid_D,
  output logic             clr_E,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             pc_misalign
);

  logic [31:0]      pcf_q, pcf_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic [31:0]      ifid_pc_q, ifid_pc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             misalign_q, misalign_d;
  logic [31:0]      npc_w;

  npc u_npc (
    .pc_f_i     (pcf_q),
    .pc_d_i     (ifid_pc_q),
    .instr_d_i  (ifid_instr_q),
    .rs_fwd_d_i (rs_fwd_D),
    .cmp_eq_d_i (cmp_eq_D),
    .npc_o      (npc_w)
  );

  // Stall outranks any redirect in D; the redirect is re-evaluated on release.
  always_comb begin
    pcf_d        = pcf_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    misalign_d   = misalign_q | (pcf_q[1:0] != 2'b00);
    if (stall) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      pcf_d        = npc_w;
      ifid_instr_d = instr_F;
      ifid_pc_d    = pcf_q;
      valid_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcf_q        <= PC_RESET;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      valid_q      <= 1'b0;
      cnt_q        <= '0;
      misalign_q   <= 1'b0;
    end else begin
      pcf_q        <= pcf_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      misalign_q   <= misalign_d;
    end
  end

  assign pc_F        = pcf_q;
  assign instr_D     = ifid_instr_q;
  assign pc_D        = ifid_pc_q;
  assign pc8_D       = ifid_pc_q + 32'd8;
  assign valid_D     = valid_q;
  assign clr_E       = stall & reset;
  assign stall_cnt   = cnt_q;
  assign pc_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// program run, all checked against an instruction-level PC/IF-ID model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, cmp_eq_D;
  logic [31:0] instr_F, rs_fwd_D;

  logic [31:0] pc_F, instr_D, pc_D, pc8_D;
  logic        valid_D, clr_E, pc_misalign;
  logic [15:0] stall_cnt;

  logic [31:0] pc_F_s, instr_D_s, pc_D_s, pc8_D_s;
  logic        valid_D_s, clr_E_s, pc_misalign_s;
  logic [1:0]  stall_cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .instr_F(instr_F),
    .cmp_eq_D(cmp_eq_D), .rs_fwd_D(rs_fwd_D),
    .pc_F(pc_F), .instr_D(instr_D), .pc_D(pc_D), .pc8_D(pc8_D),
    .valid_D(valid_D), .clr_E(clr_E), .stall_cnt(stall_cnt),
    .pc_misalign(pc_misalign)
  );

  fetch_stage #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .stall(stall), .instr_F(instr_F),
    .cmp_eq_D(cmp_eq_D), .rs_fwd_D(rs_fwd_D),
    .pc_F(pc_F_s), .instr_D(instr_D_s), .pc_D(pc_D_s), .pc8_D(pc8_D_s),
    .valid_D(valid_D_s), .clr_E(clr_E_s), .stall_cnt(stall_cnt_s),
    .pc_misalign(pc_misalign_s)
  );

  always #5 clk = ~clk;

  // Reference model: architectural PC, IF/ID contents, stall count, sticky flag.
  logic [31:0] m_pc, m_iD, m_pcD;
  logic        m_valid, m_mis;
  int          m_cnt;
  logic [31:0] mem [logic [31:0]];
  bit          rand_mode = 0;

  function automatic logic [31:0] gen_instr();
    int k;
    int off;
    k = $urandom_range(0, 9);
    if (k <= 2) return {6'h0D, 5'($urandom), 5'($urandom), 16'($urandom)};
    if (k <= 4) return {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, 6'h21};
    if (k <= 6) begin
      off = int'($urandom_range(0, 16)) - 8;
      return {6'h04, 5'd1, 5'd2, 16'(off)};
    end
    if (k == 7) return {6'h02, 26'(32'h0C00 + $urandom_range(0, 63))};
    if (k == 8) return {6'h03, 26'(32'h0C00 + $urandom_range(0, 63))};
    return {6'h00, 5'd31, 15'd0, 6'h08};
  endfunction

  function automatic logic [31:0] im_read(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = rand_mode ? gen_instr() : {6'h0D, 5'd0, 5'd1, a[15:0]};
    return mem[a];
  endfunction

  function automatic logic [31:0] ref_npc();
    int off;
    off = int'($signed(m_iD[15:0]));
    if (m_iD[31:26] == 6'd4 && cmp_eq_D) return m_pcD + 32'd4 + 32'(off * 4);
    if (m_iD[31:26] == 6'd2 || m_iD[31:26] == 6'd3) return {m_pcD[31:28], m_iD[25:0], 2'b00};
    if (m_iD[31:26] == 6'd0 && m_iD[5:0] == 6'd8) return rs_fwd_D;
    return m_pc + 32'd4;
  endfunction

  task automatic refresh();
    instr_F = im_read(m_pc);
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_iD = '0; m_pcD = '0; m_valid = 0; m_cnt = 0; m_mis = 0;
  endtask

  task automatic tick();
    logic [31:0] nxt;
    logic        was_mis;
    @(posedge clk);
    was_mis = (m_pc[1:0] != 2'b00);
    if (reset) begin
      if (stall) m_cnt++;
      else begin
        nxt = ref_npc(); m_pcD = m_pc; m_iD = instr_F; m_valid = 1; m_pc = nxt;
      end
      if (was_mis) m_mis = 1;
    end
    #1;
    refresh();
  endtask

  task automatic do_reset(input int unsigned n);
    reset = 0;
    model_reset();
    mem.delete();
    repeat (n) @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic test_reset();
    stall = 1; cmp_eq_D = 0; rs_fwd_D = '0;
    reset = 0;
    model_reset();
    mem.delete();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (pc_F !== 32'h3000 || instr_D !== '0 || pc_D !== '0 || valid_D !== 1'b0 ||
        stall_cnt !== '0 || pc_misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pc_F=%h instr_D=%h pc_D=%h valid=%b cnt=%0d mis=%b, want 3000/0/0/0/0/0",
               pc_F, instr_D, pc_D, valid_D, stall_cnt, pc_misalign);
    end
    n_tests++;
    if (clr_E !== 1'b0) begin
      n_fail++; $display("FAIL clr_in_reset: clr_E=%b want 0", clr_E);
    end
    stall = 0; reset = 1;
    refresh();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (pc_F !== 32'h3000 + 32'(4 * i) || valid_D !== (i > 0) ||
          (i > 0 && instr_D !== im_read(32'h3000 + 32'(4 * (i - 1)))) || stall_cnt !== '0) begin
        n_fail++;
        $display("FAIL straight_line[%0d]: pc_F=%h valid=%b instr_D=%h cnt=%0d", i, pc_F, valid_D, instr_D, stall_cnt);
      end
      if (i < 2) tick();
    end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 1; i <= 2; i++) begin
      #1;
      n_tests++;
      if (clr_E !== 1'b1) begin
        n_fail++; $display("FAIL stall_clr[%0d]: clr_E=%b want 1", i, clr_E);
      end
      tick();
      n_tests++;
      if (pc_F !== 32'h3008 || pc_D !== 32'h3004 || instr_D !== im_read(32'h3004) ||
          stall_cnt !== 16'(i)) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: pc_F=%h pc_D=%h instr_D=%h cnt=%0d, want 3008/3004/%h/%0d",
                 i, pc_F, pc_D, instr_D, stall_cnt, im_read(32'h3004), i);
      end
    end
    stall = 0;
    #1;
    n_tests++;
    if (clr_E !== 1'b0) begin
      n_fail++; $display("FAIL stall_clr_release: clr_E=%b want 0", clr_E);
    end
    tick();
    n_tests++;
    if (pc_F !== 32'h300C || stall_cnt !== 16'd2) begin
      n_fail++; $display("FAIL stall_resume: pc_F=%h cnt=%0d want 300c/2", pc_F, stall_cnt);
    end
  endtask

  task automatic test_beq_backward();
    mem[32'h3010] = {6'h04, 5'd1, 5'd2, 16'hFFFD};
    tick();
    tick();
    cmp_eq_D = 1;
    tick();
    n_tests++;
    if (pc_F !== 32'h3008 || pc_D !== 32'h3014 || instr_D !== im_read(32'h3014) || pc_F !== m_pc) begin
      n_fail++;
      $display("FAIL beq_backward: pc_F=%h pc_D=%h instr_D=%h, want 3008/3014/%h", pc_F, pc_D, instr_D, im_read(32'h3014));
    end
    cmp_eq_D = 0;
  endtask

  task automatic test_jal_jr();
    do_reset(2);
    mem[32'h3000] = {6'h03, 26'h0000C10};
    mem[32'h3040] = {6'h00, 5'd31, 15'd0, 6'h08};
    rs_fwd_D = '0;
    refresh();
    tick();
    n_tests++;
    if (pc_D !== 32'h3000 || pc8_D !== 32'h3008) begin
      n_fail++; $display("FAIL jal_link: pc_D=%h pc8_D=%h want 3000/3008", pc_D, pc8_D);
    end
    tick();
    n_tests++;
    if (pc_F !== 32'h3040 || pc_D !== 32'h3004) begin
      n_fail++; $display("FAIL jal_target: pc_F=%h pc_D=%h want 3040/3004", pc_F, pc_D);
    end
    tick();
    rs_fwd_D = 32'h3008;
    tick();
    n_tests++;
    if (pc_F !== 32'h3008 || pc_D !== 32'h3044) begin
      n_fail++; $display("FAIL jr_target: pc_F=%h pc_D=%h want 3008/3044", pc_F, pc_D);
    end
  endtask

  task automatic test_stall_branch();
    do_reset(1);
    mem[32'h3000] = {6'h04, 5'd1, 5'd2, 16'h0004};
    refresh();
    tick();
    stall = 1; cmp_eq_D = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (pc_F !== 32'h3004 || pc_D !== 32'h3000) begin
        n_fail++; $display("FAIL stall_branch_hold[%0d]: pc_F=%h pc_D=%h want 3004/3000", i, pc_F, pc_D);
      end
    end
    stall = 0; cmp_eq_D = 1;
    tick();
    n_tests++;
    if (pc_F !== 32'h3014 || pc_D !== 32'h3004) begin
      n_fail++; $display("FAIL stall_branch_release: pc_F=%h pc_D=%h want 3014/3004", pc_F, pc_D);
    end
    cmp_eq_D = 0;
  endtask

  task automatic test_misalign_wrap();
    do_reset(1);
    mem[32'h3000] = {6'h00, 5'd31, 15'd0, 6'h08};
    rs_fwd_D = 32'h3002;
    refresh();
    tick();
    tick();
    n_tests++;
    if (pc_F !== 32'h3002 || pc_misalign !== 1'b0) begin
      n_fail++; $display("FAIL misalign_early: pc_F=%h mis=%b want 3002/0", pc_F, pc_misalign);
    end
    tick();
    n_tests++;
    if (pc_F !== 32'h3006 || pc_misalign !== 1'b1) begin
      n_fail++; $display("FAIL misalign_set: pc_F=%h mis=%b want 3006/1", pc_F, pc_misalign);
    end
    mem[32'h300A] = {6'h00, 5'd31, 15'd0, 6'h08};
    rs_fwd_D = 32'hFFFF_FFF8;
    repeat (5) tick();
    n_tests++;
    if (pc_F !== 32'h0 || pc_D !== 32'hFFFF_FFFC || pc8_D !== 32'h4 || pc_misalign !== 1'b1) begin
      n_fail++;
      $display("FAIL pc_wrap: pc_F=%h pc_D=%h pc8_D=%h mis=%b want 0/fffffffc/4/1", pc_F, pc_D, pc8_D, pc_misalign);
    end
  endtask

  task automatic test_saturation();
    do_reset(1);
    refresh();
    stall = 1;
    repeat (5) tick();
    n_tests++;
    if (stall_cnt_s !== 2'd3 || stall_cnt !== 16'd5) begin
      n_fail++; $display("FAIL cnt_saturate: cnt2=%0d cnt16=%0d want 3/5", stall_cnt_s, stall_cnt);
    end
    stall = 0;
  endtask

  task automatic test_async_reset();
    do_reset(1);
    refresh();
    repeat (3) tick();
    stall = 1;
    tick();
    #2;
    reset = 0;
    model_reset();
    #1;
    n_tests++;
    if (pc_F !== 32'h3000 || instr_D !== '0 || pc_D !== '0 || pc8_D !== 32'h8 || valid_D !== 1'b0 ||
        stall_cnt !== '0 || stall_cnt_s !== '0 || pc_misalign !== 1'b0 || clr_E !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pc_F=%h instr_D=%h pc_D=%h valid=%b cnt=%0d clr_E=%b",
               pc_F, instr_D, pc_D, valid_D, stall_cnt, clr_E);
    end
    @(posedge clk);
    #1;
    reset = 1; stall = 0;
    refresh();
    tick();
    n_tests++;
    if (pc_F !== 32'h3004 || pc_D !== 32'h3000 || valid_D !== 1'b1) begin
      n_fail++; $display("FAIL reset_refetch: pc_F=%h pc_D=%h valid=%b want 3004/3000/1", pc_F, pc_D, valid_D);
    end
  endtask

  task automatic test_random();
    logic [145:0] exp_m, got_m;
    logic [131:0] exp_s, got_s;
    do_reset(1);
    rand_mode = 1;
    refresh();
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      cmp_eq_D = 1'($urandom);
      rs_fwd_D = 32'h3000 + 32'(4 * $urandom_range(0, 63));
      #1;
      n_tests++;
      if (clr_E !== stall || clr_E_s !== stall) begin
        n_fail++; $display("FAIL rand_clr[%0d]: clr_E=%b clr_E_s=%b want %b", i, clr_E, clr_E_s, stall);
      end
      tick();
      exp_m = {m_pc, m_iD, m_pcD, m_pcD + 32'd8, m_valid, (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt), m_mis};
      got_m = {pc_F, instr_D, pc_D, pc8_D, valid_D, stall_cnt, pc_misalign};
      exp_s = {m_pc, m_iD, m_pcD, m_pcD + 32'd8, m_valid, (m_cnt > 3) ? 2'd3 : 2'(m_cnt), m_mis};
      got_s = {pc_F_s, instr_D_s, pc_D_s, pc8_D_s, valid_D_s, stall_cnt_s, pc_misalign_s};
      n_tests++;
      if (got_m !== exp_m || got_s !== exp_s) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: got %h / %h want %h / %h", i, got_m, got_s, exp_m, exp_s);
      end
    end
    rand_mode = 0;
    stall = 0;
  endtask

  initial begin
    reset = 0; stall = 0; cmp_eq_D = 0; rs_fwd_D = '0; instr_F = '0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_stall();
    test_beq_backward();
    test_jal_jr();
    test_stall_branch();
    test_misalign_wrap();
    test_saturation();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
